// File: rtl/flag_pkg.sv
// Shared constants and types for the flag stripe generator.
// 640x480 timing, sync windows (inclusive), and a packed rgb_t colour type.
package flag_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    // Default channel width for rgb_t; the top module carries its own COLRW parameter.
    localparam int COLRW_DEFAULT = 4;

    typedef struct packed {
        logic [COLRW_DEFAULT-1:0] r;
        logic [COLRW_DEFAULT-1:0] g;
        logic [COLRW_DEFAULT-1:0] b;
    } rgb_t;

endpackage

// File: rtl/flag_stripes_display_timing.sv
// 640x480 raster counters with combinational syncs and data-enable.
// sx/sy are the registered pixel position; hsync/vsync/de/frame_end decode them.
module display_timing
    import flag_pkg::*;
#(
    parameter int CORDW = 10
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_end
);

    logic line_end;

    assign line_end  = (sx == CORDW'(H_TOTAL - 1));
    assign frame_end = line_end && (sy == CORDW'(V_TOTAL - 1));

    // Syncs are active-low inside their inclusive windows.
    assign hsync = ~((sx >= CORDW'(H_SYNC_START)) && (sx <= CORDW'(H_SYNC_END)));
    assign vsync = ~((sy >= CORDW'(V_SYNC_START)) && (sy <= CORDW'(V_SYNC_END)));
    assign de    = (sx < CORDW'(H_RES)) && (sy < CORDW'(V_RES));

    // Raster position: sx wraps at line end and advances sy; sy wraps at frame end.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sx <= '0;
            sy <= '0;
        end else if (line_end) begin
            sx <= '0;
            sy <= frame_end ? '0 : sy + 1'b1;
        end else begin
            sx <= sx + 1'b1;
        end
    end

endmodule

// File: rtl/flag_stripes.sv
// Flag stripe generator: NSTRIPE colour bands, horizontal (by sy) or vertical
// (by sx), over 640x480 timing. The stripe index is a saturating counter
// advanced at incrementally tracked boundaries, so no divider or multiplier.
// Outputs are two registers behind the raster counters.
// Optional: define FLAG_STRIPES_ANIM_EN to rotate the palette by one stripe per frame.
module flag_stripes
    import flag_pkg::*;
#(
    parameter int CORDW   = 10,
    parameter int NSTRIPE = 3,
    parameter int COLRW   = 4
) (
    input  logic                       clk_pix,
    input  logic                       rst_pix_n,
    input  logic                       vert,
    input  logic [NSTRIPE*3*COLRW-1:0] palette,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic [COLRW-1:0]           vga_r,
    output logic [COLRW-1:0]           vga_g,
    output logic [COLRW-1:0]           vga_b,
    output logic                       frame_start
);

    localparam int IDXW = 3;                  // enough for up to 8 stripes
    localparam int PIXW = 3 * COLRW;
    localparam int S_H  = V_RES / NSTRIPE;    // band height for horizontal stripes
    localparam int S_V  = H_RES / NSTRIPE;    // band width for vertical stripes

    logic [CORDW-1:0] sx, sy;
    logic             hsync, vsync, de, frame_end;

    display_timing #(.CORDW(CORDW)) u_timing (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .sx        (sx),
        .sy        (sy),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .frame_end (frame_end)
    );

    // Orientation is latched only on the last pixel of a frame so a frame is never mixed.
    logic vert_q;
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n)     vert_q <= 1'b0;
        else if (frame_end) vert_q <= vert;
    end

    logic [IDXW-1:0] offset;
`ifdef FLAG_STRIPES_ANIM_EN
    // Palette rotation advances once per frame, modulo NSTRIPE.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n)
            offset <= '0;
        else if (frame_end)
            offset <= (offset == IDXW'(NSTRIPE - 1)) ? '0 : offset + 1'b1;
    end
`else
    assign offset = '0;
`endif

    // Band axis and stripe pitch follow the latched orientation.
    logic [CORDW-1:0] coord, stride, bound;
    logic [IDXW-1:0]  cnt, idx_now;
    logic             hit;

    assign coord  = vert_q ? sx : sy;
    assign stride = vert_q ? CORDW'(S_V) : CORDW'(S_H);
    assign hit    = (coord == bound) && (cnt != IDXW'(NSTRIPE - 1));

    // Index for the current pixel: cleared at axis start, bumped on a boundary hit.
    always_comb begin
        idx_now = cnt;
        if (coord == '0)
            idx_now = '0;
        else if (hit)
            idx_now = cnt + 1'b1;
    end

    // Stripe counter and next boundary (k*S) tracked by repeated addition.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cnt   <= '0;
            bound <= CORDW'(S_H);
        end else begin
            cnt <= idx_now;
            if (coord == '0)
                bound <= stride;
            else if (hit)
                bound <= bound + stride;
        end
    end

    // Rotated palette slot: (index + offset) mod NSTRIPE, both operands < NSTRIPE.
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] sel;
    assign sum = {1'b0, idx_now} + {1'b0, offset};
    assign sel = (sum >= (IDXW+1)'(NSTRIPE)) ? IDXW'(sum - (IDXW+1)'(NSTRIPE))
                                             : sum[IDXW-1:0];

    // ---- stage p1: palette slot and raster controls ----
    logic [IDXW-1:0] sel_p1;
    logic            de_p1, hs_p1, vs_p1, fs_p1;

    // First pipeline stage captures the decoded pixel attributes.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sel_p1 <= '0;
            de_p1  <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            fs_p1  <= 1'b0;
        end else begin
            sel_p1 <= sel;
            de_p1  <= de;
            hs_p1  <= hsync;
            vs_p1  <= vsync;
            fs_p1  <= (sx == '0) && (sy == '0);
        end
    end

    // ---- stage p2: palette read and output registers ----
    // Palette is read live here, so an update shows on the next pixel read.
    logic [PIXW-1:0] pix;
    assign pix = palette[sel_p1*PIXW +: PIXW];

    // Output registers; colour is blanked outside the active area.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= de_p1 ? pix[PIXW-1 -: COLRW]         : '0;
            vga_g       <= de_p1 ? pix[2*COLRW-1 -: COLRW]      : '0;
            vga_b       <= de_p1 ? pix[COLRW-1:0]               : '0;
            vga_hsync   <= hs_p1;
            vga_vsync   <= vs_p1;
            frame_start <= fs_p1;
        end
    end

endmodule

// File: tb/tb_flag_stripes.sv
// Directed bench for flag_stripes: three instances (3, 4 and 7 stripes) share
// clock and reset. Expected colours come from hand-picked stripe indices.
module tb_flag_stripes;

    localparam int FRAME = 800 * 525;
`ifdef FLAG_STRIPES_ANIM_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    localparam logic [95:0] PAL_A = 96'hE12_FE1_093;
    localparam logic [95:0] PAL_B = 96'hF00_0F0_00F_ABC;
    localparam logic [95:0] PAL_C = 96'h777_666_555_444_333_222_111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vert_a = 1'b0;
    logic vert_b = 1'b1;
    logic vert_c = 1'b0;

    logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b, hs_c, vs_c, fs_c;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    flag_stripes #(.CORDW(10), .NSTRIPE(3), .COLRW(4)) dut_a (
        .clk_pix(clk), .rst_pix_n(rst_n), .vert(vert_a), .palette(PAL_A[35:0]),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(fs_a));

    flag_stripes #(.CORDW(10), .NSTRIPE(4), .COLRW(4)) dut_b (
        .clk_pix(clk), .rst_pix_n(rst_n), .vert(vert_b), .palette(PAL_B[47:0]),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .frame_start(fs_b));

    flag_stripes #(.CORDW(10), .NSTRIPE(7), .COLRW(4)) dut_c (
        .clk_pix(clk), .rst_pix_n(rst_n), .vert(vert_c), .palette(PAL_C[83:0]),
        .vga_hsync(hs_c), .vga_vsync(vs_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
        .frame_start(fs_c));

    // Expected colour of stripe k in frame f (palette rotates only when animated).
    function automatic logic [11:0] col(input logic [95:0] pal, input int n, input int k, input int f);
        int j;
        j = (k + ANIM * (f % n)) % n;
        return pal[j*12 +: 12];
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Wait until the output shows raster pixel (x,y) of frame f after the last reset release.
    task automatic wait_pix(input int f, input int y, input int x);
        int target;
        target = f * FRAME + y * 800 + x + 2;
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rgb_a", {r_a, g_a, b_a}, 12'h000);
        check("rst_hs_a", {11'd0, hs_a}, 12'd1);
        check("rst_vs_a", {11'd0, vs_a}, 12'd1);
        check("rst_fs_a", {11'd0, fs_a}, 12'd0);
        rst_n = 1'b1;

        // Frame 0: first pixel appears on the second edge
        @(negedge clk);
        check("fs_edge1", {11'd0, fs_a}, 12'd0);
        wait_pix(0, 0, 0);
        check("fs_edge2", {11'd0, fs_a}, 12'd1);
        check("a_f0_r0", {r_a, g_a, b_a}, col(PAL_A, 3, 0, 0));

        // Mid-frame orientation change must not affect this frame
        wait_pix(0, 100, 0);
        vert_a = 1'b1;

        wait_pix(0, 159, 0);
        check("a_row159", {r_a, g_a, b_a}, col(PAL_A, 3, 0, 0));
        wait_pix(0, 160, 0);
        check("a_row160", {r_a, g_a, b_a}, col(PAL_A, 3, 1, 0));
        wait_pix(0, 320, 0);
        check("a_row320", {r_a, g_a, b_a}, col(PAL_A, 3, 2, 0));
        wait_pix(0, 407, 10);
        check("c_row407", {r_c, g_c, b_c}, col(PAL_C, 7, 5, 0));
        wait_pix(0, 408, 10);
        check("c_row408", {r_c, g_c, b_c}, col(PAL_C, 7, 6, 0));
        wait_pix(0, 479, 600);
        check("a_row479", {r_a, g_a, b_a}, col(PAL_A, 3, 2, 0));
        check("c_row479", {r_c, g_c, b_c}, col(PAL_C, 7, 6, 0));
        wait_pix(0, 480, 0);
        check("a_row480_blank", {r_a, g_a, b_a}, 12'h000);

        // Frame 1: A and B are now vertical
        wait_pix(1, 0, 0);
        check("fs_f1", {11'd0, fs_a}, 12'd1);
        wait_pix(1, 0, 159);
        check("b_col159", {r_b, g_b, b_b}, col(PAL_B, 4, 0, 1));
        wait_pix(1, 0, 160);
        check("b_col160", {r_b, g_b, b_b}, col(PAL_B, 4, 1, 1));
        wait_pix(1, 0, 212);
        check("a_col212", {r_a, g_a, b_a}, col(PAL_A, 3, 0, 1));
        wait_pix(1, 0, 213);
        check("a_col213", {r_a, g_a, b_a}, col(PAL_A, 3, 1, 1));
        wait_pix(1, 0, 639);
        check("b_col639", {r_b, g_b, b_b}, col(PAL_B, 4, 3, 1));
        wait_pix(1, 0, 640);
        check("b_col640_rgb", {r_b, g_b, b_b}, 12'h000);
        check("b_col640_hs", {11'd0, hs_b}, 12'd1);
        wait_pix(1, 0, 655);
        check("b_col655_hs", {11'd0, hs_b}, 12'd1);
        wait_pix(1, 0, 656);
        check("b_col656_hs", {11'd0, hs_b}, 12'd0);
        wait_pix(1, 0, 751);
        check("b_col751_hs", {11'd0, hs_b}, 12'd0);
        wait_pix(1, 0, 752);
        check("b_col752_hs", {11'd0, hs_b}, 12'd1);
        wait_pix(1, 200, 500);
        check("a_f1_col500", {r_a, g_a, b_a}, col(PAL_A, 3, 2, 1));
        wait_pix(1, 300, 0);
        check("a_f1_row300", {r_a, g_a, b_a}, col(PAL_A, 3, 0, 1));

        // Asynchronous reset mid-frame
        rst_n = 1'b0;
        #1;
        check("mid_rst_rgb_a", {r_a, g_a, b_a}, 12'h000);
        check("mid_rst_rgb_c", {r_c, g_c, b_c}, 12'h000);
        check("mid_rst_hs_a", {11'd0, hs_a}, 12'd1);
        check("mid_rst_vs_a", {11'd0, vs_a}, 12'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        check("post_rst_fs1", {11'd0, fs_a}, 12'd0);
        wait_pix(0, 0, 0);
        check("post_rst_fs2", {11'd0, fs_a}, 12'd1);
        // Sampled orientation was cleared, so A is horizontal again
        wait_pix(0, 0, 300);
        check("post_rst_horiz", {r_a, g_a, b_a}, col(PAL_A, 3, 0, 0));
        wait_pix(0, 489, 799);
        check("vs_row489", {11'd0, vs_a}, 12'd1);
        wait_pix(0, 490, 0);
        check("vs_row490", {11'd0, vs_a}, 12'd0);
        wait_pix(0, 491, 799);
        check("vs_row491", {11'd0, vs_a}, 12'd0);
        wait_pix(0, 492, 0);
        check("vs_row492", {11'd0, vs_a}, 12'd1);

`ifdef FLAG_STRIPES_ANIM_EN
        // Row 0 colour rotates through the palette frame by frame
        wait_pix(1, 0, 0);
        check("anim_f1", {r_a, g_a, b_a}, PAL_A[23:12]);
        wait_pix(2, 0, 0);
        check("anim_f2", {r_a, g_a, b_a}, PAL_A[35:24]);
        wait_pix(3, 0, 0);
        check("anim_f3", {r_a, g_a, b_a}, PAL_A[11:0]);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
